// File: rtl/multi_cycle_ctrl.sv
// Main control FSM for the multi-cycle MIPS datapath: per-state control decode,
// memory-ready handshake with a bounded wait, illegal-opcode trap and retire counter.
`timescale 1ns/1ps
module multi_cycle_ctrl #(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [5:0]  instr_op_i,
  input  logic        mem_ready_i,
  output logic        PCWrite_o,
  output logic        PCWriteCond_o,
  output logic        IorD_o,
  output logic        MemRead_o,
  output logic        MemWrite_o,
  output logic        IRWrite_o,
  output logic        MemtoReg_o,
  output logic [1:0]  PCSource_o,
  output logic [2:0]  ALU_op_o,
  output logic        ALUSrcA_o,
  output logic [1:0]  ALUSrcB_o,
  output logic        RegWrite_o,
  output logic        RegDst_o,
  output logic [3:0]  state_o,
  output logic        illegal_o,
  output logic        timeout_o,
  output logic [31:0] instr_cnt_o
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,  DECODE = 4'd1,  MEMADR = 4'd2,  MEMRD = 4'd3,
    MEMWB  = 4'd4,  MEMWR  = 4'd5,  EXEC   = 4'd6,  RWB   = 4'd7,
    BRANCH = 4'd8,  IEXEC  = 4'd9,  IWB    = 4'd10, TRAP  = 4'd11
  } state_t;

  typedef struct packed {
    logic       pcWrite;
    logic       pcWriteCond;
    logic       iorD;
    logic       memRead;
    logic       memWrite;
    logic       irWrite;
    logic       memtoReg;
    logic [1:0] pcSource;
    logic [2:0] aluOp;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic       regWrite;
    logic       regDst;
  } ctrl_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_SLTI = 6'b001010;

  // waitCnt holds completed wait cycles, so the cycle that would bring it to
  // MEM_TIMEOUT is the last one; ready on that cycle still wins.
  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t      state, stateNext;
  ctrl_t       ctrl;
  logic [5:0]  opQ;
  logic [7:0]  waitCnt;
  logic [31:0] instrCnt;
  logic        illegalQ, timeoutQ;
  logic        memState, memWait, expired, retire;

  assign memState = (state == FETCH) || (state == MEMRD) || (state == MEMWR);
  assign memWait  = memState && !mem_ready_i;
  assign expired  = memWait && (waitCnt == WAIT_LAST);
  assign retire   = (stateNext == FETCH) &&
                    (state inside {MEMWB, MEMWR, RWB, BRANCH, IWB});

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= FETCH;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      FETCH:  if (mem_ready_i) stateNext = DECODE;
              else if (expired) stateNext = TRAP;
      DECODE: case (instr_op_i)
                OP_R:                     stateNext = EXEC;
                OP_LW, OP_SW:             stateNext = MEMADR;
                OP_BEQ:                   stateNext = BRANCH;
                OP_ADDI, OP_ANDI, OP_SLTI: stateNext = IEXEC;
                default:                  stateNext = TRAP;
              endcase
      MEMADR: stateNext = (opQ == OP_LW) ? MEMRD : MEMWR;
      MEMRD:  if (mem_ready_i) stateNext = MEMWB;
              else if (expired) stateNext = TRAP;
      MEMWR:  if (mem_ready_i) stateNext = FETCH;
              else if (expired) stateNext = TRAP;
      EXEC:   stateNext = RWB;
      IEXEC:  stateNext = IWB;
      MEMWB, RWB, IWB, BRANCH: stateNext = FETCH;
      TRAP:   stateNext = TRAP;
      default: stateNext = FETCH;
    endcase
  end

  always_comb begin
    ctrl = '0;
    case (state)
      FETCH: begin
        ctrl.memRead = 1'b1;
        ctrl.aluSrcB = 2'b01;
        ctrl.irWrite = mem_ready_i;
        ctrl.pcWrite = mem_ready_i;
      end
      DECODE: ctrl.aluSrcB = 2'b11;
      MEMADR: begin
        ctrl.aluSrcA = 1'b1;
        ctrl.aluSrcB = 2'b10;
      end
      MEMRD: begin
        ctrl.memRead = 1'b1;
        ctrl.iorD    = 1'b1;
      end
      MEMWB: begin
        ctrl.regWrite = 1'b1;
        ctrl.memtoReg = 1'b1;
      end
      MEMWR: begin
        ctrl.memWrite = 1'b1;
        ctrl.iorD     = 1'b1;
      end
      EXEC: begin
        ctrl.aluSrcA = 1'b1;
        ctrl.aluOp   = 3'b010;
      end
      RWB: begin
        ctrl.regWrite = 1'b1;
        ctrl.regDst   = 1'b1;
      end
      BRANCH: begin
        ctrl.aluSrcA     = 1'b1;
        ctrl.aluOp       = 3'b001;
        ctrl.pcWriteCond = 1'b1;
        ctrl.pcSource    = 2'b01;
      end
      IEXEC: begin
        ctrl.aluSrcA = 1'b1;
        ctrl.aluSrcB = 2'b10;
        case (opQ)
          OP_ANDI: ctrl.aluOp = 3'b011;
          OP_SLTI: ctrl.aluOp = 3'b100;
          default: ctrl.aluOp = 3'b000;
        endcase
      end
      IWB: ctrl.regWrite = 1'b1;
      default: ctrl = '0;
    endcase
    // FETCH decodes to an active read, so reset must mask the outputs directly
    if (rst_i) ctrl = '0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      opQ      <= '0;
      waitCnt  <= '0;
      instrCnt <= '0;
      illegalQ <= 1'b0;
      timeoutQ <= 1'b0;
    end else begin
      if (state == DECODE) opQ <= instr_op_i;
      if (stateNext != state) waitCnt <= '0;
      else if (memWait)       waitCnt <= waitCnt + 8'd1;
      if (retire) instrCnt <= instrCnt + 32'd1;
      if (state == DECODE && stateNext == TRAP) illegalQ <= 1'b1;
      if (expired) timeoutQ <= 1'b1;
    end
  end

  assign PCWrite_o     = ctrl.pcWrite;
  assign PCWriteCond_o = ctrl.pcWriteCond;
  assign IorD_o        = ctrl.iorD;
  assign MemRead_o     = ctrl.memRead;
  assign MemWrite_o    = ctrl.memWrite;
  assign IRWrite_o     = ctrl.irWrite;
  assign MemtoReg_o    = ctrl.memtoReg;
  assign PCSource_o    = ctrl.pcSource;
  assign ALU_op_o      = ctrl.aluOp;
  assign ALUSrcA_o     = ctrl.aluSrcA;
  assign ALUSrcB_o     = ctrl.aluSrcB;
  assign RegWrite_o    = ctrl.regWrite;
  assign RegDst_o      = ctrl.regDst;
  assign state_o       = state;
  assign illegal_o     = illegalQ;
  assign timeout_o     = timeoutQ;
  assign instr_cnt_o   = instrCnt;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Bench for multi_cycle_ctrl: each instruction is expanded into its list of
// steps and walked cycle by cycle against a table of expected controls.
`timescale 1ns/1ps
module tb_multi_cycle_ctrl;

  localparam int TIMEOUT = 4;
  localparam int S_FETCH = 0, S_DECODE = 1, S_MEMADR = 2, S_MEMRD = 3, S_MEMWB = 4,
                 S_MEMWR = 5, S_EXEC = 6, S_RWB = 7, S_BRANCH = 8, S_IEXEC = 9,
                 S_IWB = 10, S_TRAP = 11;
  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
                         OP_BEQ = 6'b000100, OP_ADDI = 6'b001000,
                         OP_ANDI = 6'b001100, OP_SLTI = 6'b001010;

  logic        clk_i = 1'b0, rst_i, mem_ready_i;
  logic [5:0]  instr_op_i;
  logic        PCWrite_o, PCWriteCond_o, IorD_o, MemRead_o, MemWrite_o, IRWrite_o;
  logic        MemtoReg_o, ALUSrcA_o, RegWrite_o, RegDst_o, illegal_o, timeout_o;
  logic [1:0]  PCSource_o, ALUSrcB_o;
  logic [2:0]  ALU_op_o;
  logic [3:0]  state_o;
  logic [31:0] instr_cnt_o;
  logic [16:0] ctrlVec;

  int          nChecks = 0, nPass = 0, readyPct = 100, cyc;
  logic [31:0] expCnt = 0;
  bit          readyQ[$];
  logic [5:0]  pool [7] = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_ANDI, OP_SLTI};

  multi_cycle_ctrl #(.MEM_TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .instr_op_i(instr_op_i), .mem_ready_i(mem_ready_i),
    .PCWrite_o(PCWrite_o), .PCWriteCond_o(PCWriteCond_o), .IorD_o(IorD_o),
    .MemRead_o(MemRead_o), .MemWrite_o(MemWrite_o), .IRWrite_o(IRWrite_o),
    .MemtoReg_o(MemtoReg_o), .PCSource_o(PCSource_o), .ALU_op_o(ALU_op_o),
    .ALUSrcA_o(ALUSrcA_o), .ALUSrcB_o(ALUSrcB_o), .RegWrite_o(RegWrite_o),
    .RegDst_o(RegDst_o), .state_o(state_o), .illegal_o(illegal_o),
    .timeout_o(timeout_o), .instr_cnt_o(instr_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  assign ctrlVec = {PCWrite_o, PCWriteCond_o, IorD_o, MemRead_o, MemWrite_o, IRWrite_o,
                    MemtoReg_o, PCSource_o, ALU_op_o, ALUSrcA_o, ALUSrcB_o,
                    RegWrite_o, RegDst_o};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Control table straight from the per-state output list.
  function automatic logic [16:0] expCtrl(input int s, input logic [5:0] op, input bit r);
    logic pw, pwc, iod, mr, mw, irw, m2r, asa, rw, rd;
    logic [1:0] pcs, asb;
    logic [2:0] alu;
    {pw, pwc, iod, mr, mw, irw, m2r, asa, rw, rd, pcs, asb, alu} = '0;
    case (s)
      S_FETCH:  begin mr = 1; asb = 2'b01; irw = r; pw = r; end
      S_DECODE: asb = 2'b11;
      S_MEMADR: begin asa = 1; asb = 2'b10; end
      S_MEMRD:  begin mr = 1; iod = 1; end
      S_MEMWB:  begin rw = 1; m2r = 1; end
      S_MEMWR:  begin mw = 1; iod = 1; end
      S_EXEC:   begin asa = 1; alu = 3'b010; end
      S_RWB:    begin rw = 1; rd = 1; end
      S_BRANCH: begin asa = 1; alu = 3'b001; pwc = 1; pcs = 2'b01; end
      S_IEXEC:  begin
        asa = 1; asb = 2'b10;
        alu = (op == OP_ANDI) ? 3'b011 : (op == OP_SLTI) ? 3'b100 : 3'b000;
      end
      S_IWB:    rw = 1;
      default:  ;
    endcase
    return {pw, pwc, iod, mr, mw, irw, m2r, pcs, alu, asa, asb, rw, rd};
  endfunction

  function automatic bit nextReady();
    if (readyQ.size() > 0) return readyQ.pop_front();
    return $urandom_range(0, 99) < readyPct;
  endfunction

  // Called and returns at a falling edge.
  task automatic doReset();
    rst_i = 1'b1; mem_ready_i = 1'b1; instr_op_i = 6'($urandom);
    #1;
    chk("rstState", 32'(state_o), S_FETCH);
    chk("rstCtrl", 32'(ctrlVec), 0);
    chk("rstFlags", {illegal_o, timeout_o}, 0);
    chk("rstCount", instr_cnt_o, 0);
    @(negedge clk_i);
    rst_i = 1'b0;
    expCnt = 0;
  endtask

  task automatic runInstr(input logic [5:0] op, input int abortStep, output int cycles);
    int  steps[$];
    int  waitN;
    bit  r, isMem, trapped, tmo;
    cycles = 0; trapped = 0; tmo = 0;
    steps = '{S_FETCH, S_DECODE};
    case (op)
      OP_R:                      begin steps.push_back(S_EXEC); steps.push_back(S_RWB); end
      OP_LW:                     begin steps.push_back(S_MEMADR); steps.push_back(S_MEMRD);
                                       steps.push_back(S_MEMWB); end
      OP_SW:                     begin steps.push_back(S_MEMADR); steps.push_back(S_MEMWR); end
      OP_BEQ:                    steps.push_back(S_BRANCH);
      OP_ADDI, OP_ANDI, OP_SLTI: begin steps.push_back(S_IEXEC); steps.push_back(S_IWB); end
      default:                   steps.push_back(S_TRAP);
    endcase
    for (int i = 0; i < steps.size(); i++) begin
      if (steps[i] == S_TRAP) begin trapped = 1; break; end
      isMem = (steps[i] == S_FETCH) || (steps[i] == S_MEMRD) || (steps[i] == S_MEMWR);
      waitN = 0;
      forever begin
        r = isMem ? nextReady() : 1'($urandom_range(0, 1));
        mem_ready_i = r;
        instr_op_i = (steps[i] == S_DECODE) ? op : 6'($urandom);
        #1;
        chk("state", 32'(state_o), steps[i]);
        chk("ctrl", 32'(ctrlVec), 32'(expCtrl(steps[i], op, r)));
        chk("flags", {illegal_o, timeout_o}, 0);
        chk("count", instr_cnt_o, expCnt);
        cycles++;
        if (i == abortStep) begin
          #2 rst_i = 1'b1;
          #1;
          chk("asyncState", 32'(state_o), S_FETCH);
          chk("asyncMemRead", 32'(MemRead_o), 0);
          chk("asyncCtrl", 32'(ctrlVec), 0);
          chk("asyncCount", instr_cnt_o, 0);
          @(negedge clk_i);
          rst_i = 1'b0;
          expCnt = 0;
          return;
        end
        @(negedge clk_i);
        if (!isMem || r) break;
        if (waitN == TIMEOUT - 1) begin trapped = 1; tmo = 1; break; end
        waitN++;
      end
      if (trapped) break;
    end
    if (!trapped) expCnt++;
    else begin
      for (int k = 0; k < 10; k++) begin
        mem_ready_i = 1'($urandom_range(0, 1));
        instr_op_i = 6'($urandom);
        #1;
        chk("trapState", 32'(state_o), S_TRAP);
        chk("trapCtrl", 32'(ctrlVec), 0);
        chk("trapFlags", {illegal_o, timeout_o}, {~tmo, tmo});
        chk("trapCount", instr_cnt_o, expCnt);
        @(negedge clk_i);
      end
      doReset();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_i = 1'b1; mem_ready_i = 1'b0; instr_op_i = '0;
    @(negedge clk_i);
    doReset();

    runInstr(OP_R, -1, cyc);
    chk("rCycles", cyc, 4);

    doReset();
    readyQ = '{1, 0, 0, 1};
    runInstr(OP_LW, -1, cyc);
    chk("lwCycles", cyc, 7);

    doReset();
    runInstr(OP_BEQ, -1, cyc);
    chk("beqCycles", cyc, 3);
    runInstr(OP_SLTI, -1, cyc);
    chk("sltiCycles", cyc, 4);
    #1 chk("beqSltiCount", instr_cnt_o, 2);
    #1;
    @(negedge clk_i);

    doReset();
    runInstr(6'b000010, -1, cyc);

    runInstr(OP_R, -1, cyc);
    readyQ = '{1, 0, 0, 0, 0};
    runInstr(OP_SW, -1, cyc);
    readyQ = '{1, 0, 0, 0, 1};
    runInstr(OP_SW, -1, cyc);
    chk("swLimitCycles", cyc, 7);

    runInstr(OP_ADDI, -1, cyc);
    readyQ = '{1, 0};
    runInstr(OP_LW, 3, cyc);
    runInstr(OP_ADDI, -1, cyc);
    chk("addiAfterRst", cyc, 4);

    readyPct = 60;
    readyQ.delete();
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 9) == 0) runInstr(6'($urandom), -1, cyc);
      else runInstr(pool[$urandom_range(0, 6)], -1, cyc);
    end

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
